// File: rtl/pool_pkg.sv
// Shared constants and types for the ball-pair collision resolver.
// Positions and velocities are x64 fixed-point; velocities are in x64 units per frame.
package pool_pkg;

    localparam int MULTIPLIER = 64;
    localparam int RADIUS     = 16;
    localparam int RADIUS_MUL = RADIUS * MULTIPLIER;
    localparam int DIV_W      = 48;
    localparam int V_MAX      = 4095;
    localparam int FRAC_W     = 16;

    // Squared centre distance at which two balls just touch.
    localparam logic [63:0] DIST2_MAX = 64'(2 * RADIUS_MUL) * 64'(2 * RADIUS_MUL);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        SCALE,
        APPLY
    } collide_state_t;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] vx;
        logic [31:0] vy;
        logic        enable;
    } ball_state_t;

    function automatic logic signed [63:0] sext32(input logic [31:0] v);
        return $signed({{32{v[31]}}, v});
    endfunction

    function automatic logic [31:0] sat_vel(input logic signed [63:0] v);
        if (v > 64'(V_MAX)) begin
            return 32'(V_MAX);
        end else if (v < -64'(V_MAX)) begin
            return -32'(V_MAX);
        end
        return v[31:0];
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// A zero divisor yields an all-ones quotient.
module seq_divider #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic [W:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [W:0]       shifted;

    always_comb begin
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        done_d  = 1'b0;
        shifted = {rem_q[W-1:0], quo_q[W-1]};
        if (start) begin
            quo_d = dividend;
            dvs_d = divisor;
            rem_d = '0;
            cnt_d = CNT_W'(W);
            run_d = 1'b1;
        end else if (run_q) begin
            if (shifted >= {1'b0, dvs_q}) begin
                rem_d = shifted - {1'b0, dvs_q};
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted;
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            quo_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/ball_pair_collider.sv
// Per-frame two-ball overlap/approach test and equal-mass elastic collision solve,
// producing a one-cycle velocity-load pulse for both motion stages.
module ball_pair_collider (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [31:0] a_x,
    input  logic [31:0] a_y,
    input  logic [31:0] a_vx,
    input  logic [31:0] a_vy,
    input  logic        a_enable,
    input  logic [31:0] b_x,
    input  logic [31:0] b_y,
    input  logic [31:0] b_vx,
    input  logic [31:0] b_vy,
    input  logic        b_enable,
    output logic        collision_a,
    output logic [31:0] nxt_a_vx,
    output logic [31:0] nxt_a_vy,
    output logic        collision_b,
    output logic [31:0] nxt_b_vx,
    output logic [31:0] nxt_b_vy,
    output logic        busy,
    output logic [15:0] hit_count
);

    import pool_pkg::*;

    collide_state_t    state_q, state_d;
    ball_state_t       snap_a_q, snap_a_d;
    ball_state_t       snap_b_q, snap_b_d;
    logic [31:0]       nxt_a_vx_q, nxt_a_vx_d, nxt_a_vy_q, nxt_a_vy_d;
    logic [31:0]       nxt_b_vx_q, nxt_b_vx_d, nxt_b_vy_q, nxt_b_vy_d;
    logic              collision_q, collision_d;
    logic [15:0]       hit_count_q, hit_count_d;

    logic signed [63:0] dx, dy, dvx, dvy, dot, k, ex, ey;
    logic [63:0]        dist2, dot_mag;
    logic               go, div_start, div_done;
    logic [DIV_W-1:0]   div_dividend, div_divisor, div_quotient;

    // Geometry is always derived from the snapshot, so CHECK and SCALE share it.
    always_comb begin
        dx      = sext32(snap_a_q.x) - sext32(snap_b_q.x);
        dy      = sext32(snap_a_q.y) - sext32(snap_b_q.y);
        dvx     = sext32(snap_a_q.vx) - sext32(snap_b_q.vx);
        dvy     = sext32(snap_a_q.vy) - sext32(snap_b_q.vy);
        dist2   = 64'(dx * dx) + 64'(dy * dy);
        dot     = dvx * dx + dvy * dy;
        dot_mag = 64'(-dot);
        go      = snap_a_q.enable && snap_b_q.enable && (dist2 != '0)
                  && (dist2 <= DIST2_MAX) && (dot < 0);
        div_dividend = DIV_W'(dot_mag << FRAC_W);
        div_divisor  = DIV_W'(dist2);
        // DIV is only entered with dot<0, so k is always the negated quotient.
        k  = -$signed({{(64 - DIV_W){1'b0}}, div_quotient});
        ex = (k * dx) >>> FRAC_W;
        ey = (k * dy) >>> FRAC_W;
    end

    seq_divider #(.W(DIV_W)) u_div (
        .clk      (clk),
        .resetN   (resetN),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_comb begin
        state_d     = state_q;
        snap_a_d    = snap_a_q;
        snap_b_d    = snap_b_q;
        nxt_a_vx_d  = nxt_a_vx_q;
        nxt_a_vy_d  = nxt_a_vy_q;
        nxt_b_vx_d  = nxt_b_vx_q;
        nxt_b_vy_d  = nxt_b_vy_q;
        collision_d = 1'b0;
        hit_count_d = hit_count_q;
        div_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (startOfFrame) begin
                    snap_a_d = '{x: a_x, y: a_y, vx: a_vx, vy: a_vy, enable: a_enable};
                    snap_b_d = '{x: b_x, y: b_y, vx: b_vx, vy: b_vy, enable: b_enable};
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (go) begin
                    div_start = 1'b1;
                    state_d   = DIV;
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                nxt_a_vx_d  = sat_vel(sext32(snap_a_q.vx) - ex);
                nxt_a_vy_d  = sat_vel(sext32(snap_a_q.vy) - ey);
                nxt_b_vx_d  = sat_vel(sext32(snap_b_q.vx) + ex);
                nxt_b_vy_d  = sat_vel(sext32(snap_b_q.vy) + ey);
                collision_d = 1'b1;
                hit_count_d = hit_count_q + 16'd1;
                state_d     = APPLY;
            end
            APPLY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            snap_a_q    <= '0;
            snap_b_q    <= '0;
            nxt_a_vx_q  <= '0;
            nxt_a_vy_q  <= '0;
            nxt_b_vx_q  <= '0;
            nxt_b_vy_q  <= '0;
            collision_q <= 1'b0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            snap_a_q    <= snap_a_d;
            snap_b_q    <= snap_b_d;
            nxt_a_vx_q  <= nxt_a_vx_d;
            nxt_a_vy_q  <= nxt_a_vy_d;
            nxt_b_vx_q  <= nxt_b_vx_d;
            nxt_b_vy_q  <= nxt_b_vy_d;
            collision_q <= collision_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign collision_a = collision_q;
    assign collision_b = collision_q;
    assign nxt_a_vx    = nxt_a_vx_q;
    assign nxt_a_vy    = nxt_a_vy_q;
    assign nxt_b_vx    = nxt_b_vx_q;
    assign nxt_b_vy    = nxt_b_vy_q;
    assign busy        = (state_q != IDLE);
    assign hit_count   = hit_count_q;

endmodule

// File: tb/tb_ball_pair_collider.sv
// Directed-vector bench for ball_pair_collider with hand-computed expectations.
module tb_ball_pair_collider;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [31:0] a_x, a_y, a_vx, a_vy, b_x, b_y, b_vx, b_vy;
    logic        a_enable, b_enable;
    logic        collision_a, collision_b, busy;
    logic [31:0] nxt_a_vx, nxt_a_vy, nxt_b_vx, nxt_b_vy;
    logic [15:0] hit_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations captured by run_frame.
    int          pulse_at;
    int          pulse_cycles;
    logic        pulse_b;
    logic        busy_at1, busy_at2;
    logic [31:0] cap_a_vx, cap_a_vy, cap_b_vx, cap_b_vy;
    logic [15:0] cap_hits;

    localparam int P = 64;

    ball_pair_collider dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .a_x          (a_x),
        .a_y          (a_y),
        .a_vx         (a_vx),
        .a_vy         (a_vy),
        .a_enable     (a_enable),
        .b_x          (b_x),
        .b_y          (b_y),
        .b_vx         (b_vx),
        .b_vy         (b_vy),
        .b_enable     (b_enable),
        .collision_a  (collision_a),
        .nxt_a_vx     (nxt_a_vx),
        .nxt_a_vy     (nxt_a_vy),
        .collision_b  (collision_b),
        .nxt_b_vx     (nxt_b_vx),
        .nxt_b_vy     (nxt_b_vy),
        .busy         (busy),
        .hit_count    (hit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Launches one frame and watches 70 cycles; pulse_at = -1 if no pulse appears.
    task automatic run_frame(input int ax, input int ay, input int avx, input int avy,
                             input logic ae, input int bx, input int by, input int bvx,
                             input int bvy, input logic be);
        a_x = ax; a_y = ay; a_vx = avx; a_vy = avy; a_enable = ae;
        b_x = bx; b_y = by; b_vx = bvx; b_vy = bvy; b_enable = be;
        @(negedge clk);
        startOfFrame = 1'b1;
        @(posedge clk);
        #1 startOfFrame = 1'b0;
        pulse_at     = -1;
        pulse_cycles = 0;
        pulse_b      = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) busy_at1 = busy;
            if (i == 2) busy_at2 = busy;
            if (collision_a) begin
                pulse_cycles++;
                if (pulse_at < 0) begin
                    pulse_at = i;
                    pulse_b  = collision_b;
                    cap_a_vx = nxt_a_vx;
                    cap_a_vy = nxt_a_vy;
                    cap_b_vx = nxt_b_vx;
                    cap_b_vy = nxt_b_vy;
                    cap_hits = hit_count;
                end
            end
        end
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0;
        a_x = '0; a_y = '0; a_vx = '0; a_vy = '0; a_enable = 1'b0;
        b_x = '0; b_y = '0; b_vx = '0; b_vy = '0; b_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_collision_a", 64'(collision_a), 0);
        check("rst_collision_b", 64'(collision_b), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_hits", 64'(hit_count), 0);
        check("rst_nxt_a_vx", $signed(nxt_a_vx), 0);
        check("rst_nxt_b_vy", $signed(nxt_b_vy), 0);
        @(negedge clk);
        resetN = 1'b1;
        repeat (2) @(posedge clk);

        // Head-on along x: velocities essentially exchange (-99/99 after flooring).
        run_frame(200*P, 200*P, 100, 0, 1'b1, 230*P, 200*P, -100, 0, 1'b1);
        check("t1_latency", pulse_at, 51);
        check("t1_width", pulse_cycles, 1);
        check("t1_pulse_b", 64'(pulse_b), 1);
        check("t1_busy_mid", 64'(busy_at1), 1);
        check("t1_a_vx", $signed(cap_a_vx), -99);
        check("t1_a_vy", $signed(cap_a_vy), 0);
        check("t1_b_vx", $signed(cap_b_vx), 99);
        check("t1_b_vy", $signed(cap_b_vy), 0);
        check("t1_hits", 64'(cap_hits), 1);
        check("t1_busy_end", 64'(busy), 0);

        // Separating: dot > 0.
        run_frame(200*P, 200*P, -100, 0, 1'b1, 230*P, 200*P, 100, 0, 1'b1);
        check("t2_no_pulse", pulse_at, -1);
        check("t2_busy_n2", 64'(busy_at2), 0);
        check("t2_hold_a_vx", $signed(nxt_a_vx), -99);
        check("t2_hold_b_vx", $signed(nxt_b_vx), 99);

        // Too far apart: dist2 = 6553600.
        run_frame(200*P, 200*P, 100, 0, 1'b1, 240*P, 200*P, -100, 0, 1'b1);
        check("t3_no_pulse", pulse_at, -1);

        // Coincident centres.
        run_frame(200*P, 200*P, 100, 0, 1'b1, 200*P, 200*P, -100, 0, 1'b1);
        check("t4_coincident", pulse_at, -1);

        // Ball B off the table.
        run_frame(200*P, 200*P, 100, 0, 1'b1, 230*P, 200*P, -100, 0, 1'b0);
        check("t4_b_disabled", pulse_at, -1);
        check("t4_hits", 64'(hit_count), 1);

        // Head-on along y.
        run_frame(200*P, 200*P, 0, 100, 1'b1, 200*P, 230*P, 0, -100, 1'b1);
        check("ty_latency", pulse_at, 51);
        check("ty_a_vx", $signed(cap_a_vx), 0);
        check("ty_a_vy", $signed(cap_a_vy), -99);
        check("ty_b_vy", $signed(cap_b_vy), 99);
        check("ty_hits", 64'(cap_hits), 2);

        // Exchange of +/-6000 exceeds the clamp: k*dx>>16 = 12000 exactly.
        run_frame(200*P, 200*P, 6000, 0, 1'b1, 230*P, 200*P, -6000, 0, 1'b1);
        check("t5_latency", pulse_at, 51);
        check("t5_a_vx_sat", $signed(cap_a_vx), -4095);
        check("t5_b_vx_sat", $signed(cap_b_vx), 4095);
        check("t5_hits", 64'(cap_hits), 3);

        // Reset while dividing.
        a_x = 200*P; a_y = 200*P; a_vx = 100; a_vy = 0; a_enable = 1'b1;
        b_x = 230*P; b_y = 200*P; b_vx = -100; b_vy = 0; b_enable = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b1;
        @(posedge clk);
        #1 startOfFrame = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t6_busy_in_div", 64'(busy), 1);
        resetN = 1'b0;
        #2;
        check("t6_rst_busy", 64'(busy), 0);
        check("t6_rst_hits", 64'(hit_count), 0);
        check("t6_rst_a_vx", $signed(nxt_a_vx), 0);
        check("t6_rst_b_vx", $signed(nxt_b_vx), 0);
        @(negedge clk);
        resetN = 1'b1;
        pulse_at = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (collision_a && pulse_at < 0) pulse_at = i;
        end
        check("t6_no_pulse", pulse_at, -1);

        run_frame(200*P, 200*P, 100, 0, 1'b1, 230*P, 200*P, -100, 0, 1'b1);
        check("t6_again_latency", pulse_at, 51);
        check("t6_again_a_vx", $signed(cap_a_vx), -99);
        check("t6_again_b_vx", $signed(cap_b_vx), 99);
        check("t6_again_hits", 64'(cap_hits), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
